// File: rtl/mandelbrot_pixel_scheduler_if.sv
// Handshake and bus bundle between the pixel scheduler, its host, the iterator and the pixel memory.
interface mandelbrot_pixel_scheduler_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              start;
    logic [26:0]       x_start;
    logic [26:0]       y_start;
    logic [26:0]       dx;
    logic [26:0]       dy;
    logic [15:0]       max_iter;
    logic [26:0]       iter_c_r;
    logic [26:0]       iter_c_i;
    logic [15:0]       iter_max;
    logic              iter_reset_n;
    logic              iter_done;
    logic [15:0]       iter_total;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              frame_done;
    logic [31:0]       frame_cycles;

    // Scheduler side
    modport master (
        input  start, x_start, y_start, dx, dy, max_iter, iter_done, iter_total,
        output iter_c_r, iter_c_i, iter_max, iter_reset_n,
        output wr_en, wr_addr, wr_data, busy, frame_done, frame_cycles
    );

    // Host / iterator / memory side
    modport slave (
        output start, x_start, y_start, dx, dy, max_iter, iter_done, iter_total,
        input  iter_c_r, iter_c_i, iter_max, iter_reset_n,
        input  wr_en, wr_addr, wr_data, busy, frame_done, frame_cycles
    );
endinterface

// File: rtl/mandelbrot_pixel_scheduler.sv
// Raster sweep in front of the mandelbrot iterator: one pixel at a time, restart, wait, colour, write.
// Optional frame cycle counter enabled by defining MANDEL_CYCLE_COUNT_EN.
module mandelbrot_pixel_scheduler #(
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_PIXELS = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input logic                    clock,
    input logic                    reset,
    mandelbrot_pixel_scheduler_if.master bus
);
    localparam int unsigned CW    = 27;
    localparam int unsigned IW    = 16;
    localparam int unsigned COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned ROW_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, WRITE} state_t;

    state_t            state;
    logic [CW-1:0]     x0_q, dx_q, dy_q, c_r_q, c_i_q;
    logic [IW-1:0]     max_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              iter_rst_n_q, wr_en_q, busy_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              last_col, last_pixel;

    assign last_col   = (col == COL_W'(H_PIXELS - 1));
    assign last_pixel = last_col && (row == ROW_W'(V_PIXELS - 1));

    // RGB332 palette by escape band; points that hit the cap are black
    function automatic logic [7:0] colour_of(input logic [IW-1:0] total, input logic [IW-1:0] cap);
        if (total >= cap)            return 8'h00;
        else if (total < IW'(8))     return 8'h03;
        else if (total < IW'(16))    return 8'h1F;
        else if (total < IW'(32))    return 8'h1C;
        else if (total < IW'(64))    return 8'hFC;
        else if (total < IW'(128))   return 8'hE0;
        else                         return 8'hE3;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            x0_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            c_r_q        <= '0;
            c_i_q        <= '0;
            max_q        <= '0;
            col          <= '0;
            row          <= '0;
            iter_rst_n_q <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    iter_rst_n_q <= 1'b0;
                    if (bus.start) begin
                        x0_q   <= bus.x_start;
                        dx_q   <= bus.dx;
                        dy_q   <= bus.dy;
                        max_q  <= bus.max_iter;
                        c_r_q  <= bus.x_start;
                        c_i_q  <= bus.y_start;
                        col    <= '0;
                        row    <= '0;
                        addr_q <= '0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    iter_rst_n_q <= 1'b1;
                    state        <= RUN;
                end
                RUN: begin
                    if (bus.iter_done) begin
                        data_q       <= colour_of(bus.iter_total, max_q);
                        wr_en_q      <= 1'b1;
                        iter_rst_n_q <= 1'b0;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_pixel) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        state  <= LOAD;
                        // Coordinates wrap modulo 2^27 by design
                        if (!last_col) begin
                            col   <= col + COL_W'(1);
                            c_r_q <= c_r_q + dx_q;
                        end else begin
                            col   <= '0;
                            row   <= row + ROW_W'(1);
                            c_r_q <= x0_q;
                            c_i_q <= c_i_q - dy_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MANDEL_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt, cyc_next, frame_cycles_q;
    logic        start_accept, frame_end;

    assign start_accept = (state == IDLE) && bus.start;
    assign frame_end    = (state == WRITE) && last_pixel;
    assign cyc_next     = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

    // Counts busy cycles; the final WRITE cycle is included in the snapshot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt        <= '0;
            frame_cycles_q <= '0;
        end else if (start_accept) begin
            cyc_cnt <= '0;
        end else if (busy_q) begin
            cyc_cnt <= cyc_next;
            if (frame_end) frame_cycles_q <= cyc_next;
        end
    end

    assign bus.frame_cycles = frame_cycles_q;
`else
    assign bus.frame_cycles = '0;
`endif

    assign bus.iter_c_r     = c_r_q;
    assign bus.iter_c_i     = c_i_q;
    assign bus.iter_max     = max_q;
    assign bus.iter_reset_n = iter_rst_n_q;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = addr_q;
    assign bus.wr_data      = data_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = done_q;
endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Bench for mandelbrot_pixel_scheduler on a 4x2 raster with a real-valued iterator model and a frame scoreboard.
module tb_mandelbrot_pixel_scheduler;
    localparam int unsigned H    = 4;
    localparam int unsigned V    = 2;
    localparam int unsigned NPIX = H * V;
    localparam int unsigned AW   = 3;

    logic clock = 1'b0;
    logic reset;

    mandelbrot_pixel_scheduler_if #(.ADDR_W(AW)) bus();

    mandelbrot_pixel_scheduler #(.H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [26:0] obs_cr   [NPIX];
    logic [26:0] obs_ci   [NPIX];
    logic [7:0]  obs_data [NPIX];
    logic [26:0] exp_cr   [NPIX];
    logic [26:0] exp_ci   [NPIX];
    logic [7:0]  exp_data [NPIX];

    // Escape count of z <- z^2 + c from z=0, capped; the iterator's contract
    function automatic int unsigned escape(input logic [26:0] cr, input logic [26:0] ci, input int unsigned cap);
        real x0, y0, zr, zi, t;
        int unsigned n;
        x0 = $itor($signed(cr)) / 8388608.0;
        y0 = $itor($signed(ci)) / 8388608.0;
        zr = 0.0; zi = 0.0; n = 0;
        while (n < cap && (zr * zr + zi * zi) <= 4.0) begin
            t  = zr * zr - zi * zi + x0;
            zi = 2.0 * zr * zi + y0;
            zr = t;
            n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] ref_colour(input int unsigned k, input int unsigned cap);
        if (k >= cap) return 8'h00;
        if (k < 8)    return 8'h03;
        if (k < 16)   return 8'h1F;
        if (k < 32)   return 8'h1C;
        if (k < 64)   return 8'hFC;
        if (k < 128)  return 8'hE0;
        return 8'hE3;
    endfunction

    // Iterator: cleared while restart is low, then counts until it reaches its escape count
    logic [15:0] it_cnt, it_target;
    assign bus.iter_total = it_cnt;
    assign bus.iter_done  = bus.iter_reset_n && (it_cnt == it_target);

    always @(posedge clock) begin
        if (!bus.iter_reset_n) begin
            it_cnt    <= 16'd0;
            it_target <= 16'(escape(bus.iter_c_r, bus.iter_c_i, int'(bus.iter_max)));
        end else if (!bus.iter_done) begin
            it_cnt <= it_cnt + 16'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".iter_reset_n"}, 64'(bus.iter_reset_n), 64'd0);
        check({tag, ".wr_en"},        64'(bus.wr_en),        64'd0);
        check({tag, ".busy"},         64'(bus.busy),         64'd0);
        check({tag, ".frame_done"},   64'(bus.frame_done),   64'd0);
        check({tag, ".wr_addr"},      64'(bus.wr_addr),      64'd0);
        check({tag, ".wr_data"},      64'(bus.wr_data),      64'd0);
        check({tag, ".iter_c_r"},     64'(bus.iter_c_r),     64'd0);
        check({tag, ".iter_c_i"},     64'(bus.iter_c_i),     64'd0);
        check({tag, ".iter_max"},     64'(bus.iter_max),     64'd0);
        check({tag, ".frame_cycles"}, 64'(bus.frame_cycles), 64'd0);
    endtask

    // One frame against the model; optional ignored mid-frame start, optional reset after abort_after writes
    task automatic run_frame(input string name, input logic [26:0] xs, input logic [26:0] ys,
                             input logic [26:0] dxv, input logic [26:0] dyv, input logic [15:0] mi,
                             input bit mid_start, input int abort_after);
        int exp_cycles, budget, cyc, n, last_w, busy_cnt, stray;
        bit got_done;
        exp_cycles = 0;
        for (int p = 0; p < int'(NPIX); p++) begin
            int unsigned k;
            exp_cr[p]   = 27'(xs + dxv * 27'(p % int'(H)));
            exp_ci[p]   = 27'(ys - dyv * 27'(p / int'(H)));
            k           = escape(exp_cr[p], exp_ci[p], int'(mi));
            exp_data[p] = ref_colour(k, int'(mi));
            exp_cycles += int'(k) + 3;
        end
        budget = exp_cycles + 50;

        @(negedge clock);
        bus.x_start = xs; bus.y_start = ys; bus.dx = dxv; bus.dy = dyv; bus.max_iter = mi;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;

        cyc = 0; n = 0; last_w = -10; busy_cnt = 0; got_done = 1'b0;
        while (!got_done && cyc < budget) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (mid_start && cyc == 5) begin bus.start = 1'b1; bus.x_start = ~xs; end
            if (mid_start && cyc == 6) bus.start = 1'b0;
            if (bus.wr_en === 1'b1) begin
                if (n < int'(NPIX)) begin
                    check({name, ".wr_addr"},  64'(bus.wr_addr),  64'(n));
                    check({name, ".wr_data"},  64'(bus.wr_data),  64'(exp_data[n]));
                    check({name, ".iter_c_r"}, 64'(bus.iter_c_r), 64'(exp_cr[n]));
                    check({name, ".iter_c_i"}, 64'(bus.iter_c_i), 64'(exp_ci[n]));
                    check({name, ".iter_max"}, 64'(bus.iter_max), 64'(mi));
                    if (mi == 16'd0 && n > 0) check({name, ".write_spacing"}, 64'(cyc - last_w), 64'd3);
                    obs_cr[n] = bus.iter_c_r; obs_ci[n] = bus.iter_c_i; obs_data[n] = bus.wr_data;
                end else begin
                    check({name, ".write_count"}, 64'(n), 64'(NPIX - 1));
                end
                last_w = cyc;
                n++;
                if (abort_after >= 0 && n == abort_after) begin
                    @(negedge clock);
                    @(negedge clock);
                    reset = 1'b1;
                    #1;
                    check_reset_outputs({name, ".midreset"});
                    stray = 0;
                    repeat (30) begin
                        @(negedge clock);
                        if (bus.wr_en !== 1'b0 || bus.frame_done !== 1'b0) stray++;
                    end
                    check({name, ".no_write_after_reset"}, 64'(stray), 64'd0);
                    reset = 1'b0;
                    @(negedge clock);
                    return;
                end
            end
            if (bus.frame_done === 1'b1) begin
                got_done = 1'b1;
                check({name, ".write_count"},   64'(n),                 64'(NPIX));
                check({name, ".done_latency"},  64'(cyc - last_w),      64'd1);
                check({name, ".busy_at_done"},  64'(bus.busy),          64'd0);
                check({name, ".busy_cycles"},   64'(busy_cnt),          64'(exp_cycles));
`ifdef MANDEL_CYCLE_COUNT_EN
                check({name, ".frame_cycles"},  64'(bus.frame_cycles),  64'(exp_cycles));
`else
                check({name, ".frame_cycles"},  64'(bus.frame_cycles),  64'd0);
`endif
            end
            cyc++;
            @(negedge clock);
        end
        check({name, ".frame_done_seen"}, 64'(got_done), 64'd1);
        if (got_done) check({name, ".done_pulse"}, 64'(bus.frame_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.x_start = '0; bus.y_start = '0; bus.dx = '0; bus.dy = '0; bus.max_iter = '0;
        repeat (4) begin
            @(negedge clock);
            bus.start = ~bus.start;
            bus.x_start = 27'($urandom);
            bus.max_iter = 16'($urandom);
        end
        @(negedge clock);
        check_reset_outputs("reset_hold");
        bus.start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_busy", 64'(bus.busy), 64'd0);

        run_frame("basic", 27'h7000000, 27'h0000000, 27'h0800000, 27'h0400000, 16'd20, 1'b0, -1);
        check("basic.cr0", 64'(obs_cr[0]), 64'h7000000);
        check("basic.cr1", 64'(obs_cr[1]), 64'h7800000);
        check("basic.cr2", 64'(obs_cr[2]), 64'h0000000);
        check("basic.cr3", 64'(obs_cr[3]), 64'h0800000);
        check("basic.ci4", 64'(obs_ci[4]), 64'h7C00000);
        check("basic.c0_black", 64'(obs_data[2]), 64'h00);
        check("basic.c1_escape", 64'(obs_data[3]), 64'h03);

        run_frame("zero_iter", 27'h7000000, 27'h0000000, 27'h0800000, 27'h0400000, 16'd0, 1'b0, -1);
        for (int p = 0; p < int'(NPIX); p++) check("zero_iter.black", 64'(obs_data[p]), 64'h00);

        run_frame("escape", 27'h1000000, 27'h0000000, 27'h0000000, 27'h0000000, 16'd1000, 1'b0, -1);
        check("escape.colour", 64'(obs_data[0]), 64'h03);

        run_frame("mid_start", 27'h7400000, 27'h0400000, 27'h0200000, 27'h0200000, 16'd30, 1'b1, -1);
        run_frame("abort", 27'h7400000, 27'h0400000, 27'h0200000, 27'h0200000, 16'd10, 1'b0, 3);
        run_frame("restart", 27'h7800000, 27'h0100000, 27'h0100000, 27'h0300000, 16'd40, 1'b0, -1);

        run_frame("wrap", 27'h3FFFFFF, 27'h0000000, 27'h0000001, 27'h0000001, 16'd5, 1'b0, -1);
        check("wrap.cr1", 64'(obs_cr[1]), 64'h4000000);

        for (int r = 0; r < 6; r++) begin
            logic [26:0] xs, ys, dxv, dyv;
            logic [15:0] mi;
            xs  = 27'(int'($urandom_range(0, 25165824)) - 20971520);
            ys  = 27'(int'($urandom_range(0, 16777216)) - 8388608);
            dxv = 27'($urandom_range(0, 4194304));
            dyv = 27'($urandom_range(0, 4194304));
            mi  = 16'($urandom_range(0, 150));
            run_frame("random", xs, ys, dxv, dyv, mi, 1'b0, -1);
        end
        run_frame("random_wide", 27'($urandom), 27'($urandom), 27'($urandom), 27'($urandom),
                  16'($urandom_range(0, 20)), 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mandelbrot_pixel_scheduler.md
Name: mandelbrot_pixel_scheduler

Overview:
Upstream control stage for the mandelbrot iterator. Sweeps a raster of pixels and computes each pixel's complex coordinate c = c_r + j*c_i (4.23 signed fixed point). For each pixel it restarts the iterator, waits for done, maps total_iter to an 8-bit RGB332 colour and issues one write to the pixel memory. Processes one pixel at a time; no overlap between pixels.

Parameters:
H_PIXELS, 640, pixels per row
V_PIXELS, 480, rows per frame
ADDR_W, 19, pixel memory address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
x_start  in  27  signed 4.23; c_r of column 0
y_start  in  27  signed 4.23; c_i of row 0 (top row)
dx  in  27  signed 4.23; c_r increment per column
dy  in  27  signed 4.23; c_i decrement per row
max_iter  in  16  iteration cap, passed through to the iterator
iter_c_r  out  27  c_r to the iterator
iter_c_i  out  27  c_i to the iterator
iter_max  out  16  registered copy of max_iter, latched at start
iter_reset_n  out  1  active-low iterator restart
iter_done  in  1  iterator done
iter_total  in  16  iterator total_iter
wr_en  out  1  pixel write strobe
wr_addr  out  ADDR_W  row*H_PIXELS + col
wr_data  out  8  RGB332 colour
busy  out  1  high from the cycle after an accepted start until the return to IDLE
frame_done  out  1  one-cycle pulse after the last pixel write
frame_cycles  out  32  cycles spent on the last frame (see Optional Feature)

Behaviour:
- Async reset: state=IDLE; iter_reset_n=0; wr_en=0; busy=0; frame_done=0; wr_addr=0; wr_data=0; iter_c_r=0; iter_c_i=0; iter_max=0; col=row=0; frame_cycles=0. A reset mid-frame abandons the frame: no further writes, no frame_done.
- All outputs are registered.
- States:
  - IDLE: iter_reset_n=0. On start: latch x_start, y_start, dx, dy, max_iter; iter_c_r<=x_start; iter_c_i<=y_start; col=row=0; go to LOAD.
  - LOAD: 1 cycle. iter_reset_n=0, so the iterator clears z and its count on this edge. Go to RUN.
  - RUN: iter_reset_n=1. Sample iter_done every cycle. When iter_done=1: colour<=map(iter_total); go to WRITE.
  - WRITE: 1 cycle. wr_en=1; wr_addr=row*H_PIXELS+col; wr_data=colour; iter_reset_n=0.
    - Not last pixel: go to LOAD and step the coordinate.
    - Last pixel: go to IDLE and pulse frame_done.
- start outside IDLE is ignored.
- Coordinate step (on leaving WRITE):
  - If col<H_PIXELS-1: col+1; iter_c_r+=dx.
  - Else: col=0; row+1; iter_c_r=x_start; iter_c_i-=dy.
- Coordinate arithmetic is 27-bit two's complement, wraps modulo 2^27, no saturation.
- wr_addr is a running counter, incremented on each write; not a multiply.
- Per-pixel latency: LOAD(1) + RUN(k+1) + WRITE(1), where k = iter_total at done. For max_iter=0, each pixel takes 3 cycles.
- Colour map, first match wins:
  - iter_total>=iter_max: 0x00
  - <8: 0x03
  - <16: 0x1F
  - <32: 0x1C
  - <64: 0xFC
  - <128: 0xE0
  - otherwise: 0xE3

Optional Feature:
MANDEL_CYCLE_COUNT_EN
- Defined: a 32-bit counter clears on an accepted start and increments every busy cycle. At frame_done it is copied to frame_cycles, which holds until the next frame_done or reset. The counter saturates at 0xFFFFFFFF.
- Undefined: no counter is built; frame_cycles is tied to 0.

Test Plan:
- Reset: assert reset mid-clock -> all outputs immediately reset values; hold reset, toggle start -> no state change.
- H_PIXELS=4, V_PIXELS=2, x_start=-2.0 (27'h7000000), y_start=0, dx=1.0 (27'h0800000), dy=0.5, max_iter=20, start -> 8 writes.
  - Addresses 0..7.
  - Row-0 iter_c_r sequence -2,-1,0,+1.
  - Row-1 iter_c_i = -0.5.
  - Pixel c=0 gets wr_data=0x00.
  - frame_done one cycle after the write to address 7.
- max_iter=0, 4x2 frame -> every wr_data=0x00; consecutive writes exactly 3 cycles apart; busy high for 24 cycles.
- Escape colour: c_r=+2.0, c_i=0, max_iter=1000 -> iter_total small (<8), wr_data=0x03.
- start pulsed while busy -> ignored, frame addresses unchanged. Assert reset at pixel 3 -> no write to address 3+, no frame_done. Next start restarts at address 0.
- Wrap: x_start=27'h3FFFFFF, dx=1 LSB, H_PIXELS=2 -> second iter_c_r=27'h4000000 (wraps negative).
- With MANDEL_CYCLE_COUNT_EN: max_iter=0, 4x2 frame -> frame_cycles=24.
